mem_wait_ctrl: RTL and testbench

//  Unified instruction/data memory with a ready handshake for the multi-cycle MIPS core.
//  It sits directly downstream of the IorD address mux, and it feeds the IR and MDR latches.
//  It models a slow memory with programmable wait states. The control unit holds its

---
 rtl/mem_wait_ctrl.sv | 116 +++++++++++
 tb/tb_mem_wait_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - unified instruction/data memory with programmable wait states and ready handshake
module mem_wait_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic          lat_wr;

    logic          req;
    logic          bad;
    logic          go_done;
    logic          acc_wr;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic          init_ok;
    logic          unused_bits;

    assign req         = mem_rd | mem_wr;
    assign bad         = (addr[1:0] != 2'b00) || (mem_rd && mem_wr);
    assign busy        = (state == S_WAIT) || (state == S_DONE);
    assign init_ok     = (state == S_IDLE) && !req && init_we;
    assign unused_bits = ^{addr[31:AW+2], init_addr[31:AW+2], init_addr[1:0]};

    // The access that completes on this edge: live inputs on the zero-wait path, latched ones otherwise.
    always_comb begin
        go_done   = 1'b0;
        acc_wr    = lat_wr;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        if (state == S_IDLE && req && !bad && WAIT_STATES == 0) begin
            go_done   = 1'b1;
            acc_wr    = mem_wr;
            acc_idx   = addr[AW+1:2];
            acc_wdata = wdata;
        end else if (state == S_WAIT && req && cnt == 4'd0) begin
            go_done = 1'b1;
        end
    end

    // Array has no reset; reset only blocks writes that have not yet reached the DONE edge.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            if (go_done && acc_wr)
                mem[acc_idx] <= acc_wdata;
            else if (init_ok)
                mem[init_addr[AW+1:2]] <= init_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_wr    <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req && bad) begin
                        err <= 1'b1;
                    end else if (req) begin
                        lat_idx   <= addr[AW+1:2];
                        lat_wdata <= wdata;
                        lat_wr    <= mem_wr;
                        cnt       <= CNT_INIT;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req)
                        state <= S_IDLE;
                    else if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (go_done) begin
                state <= S_DONE;
                ready <= 1'b1;
                if (!acc_wr)
                    rdata <= mem[acc_idx];
            end
        end
    end
endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb/tb_mem_wait_ctrl.sv - directed self-checking bench for mem_wait_ctrl (2 and 0 wait states)
module tb_mem_wait_ctrl;
    logic        CLK = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr, init_we;
    logic [31:0] addr, wdata, init_addr, init_data;
    logic [31:0] rdata2, rdata0;
    logic        ready2, busy2, err2, ready0, busy0, err0;
    int          total = 0;
    int          fails = 0;
    logic [31:0] data;
    int          lat;

    always #5 CLK = ~CLK;

    mem_wait_ctrl #(.DEPTH(1024), .WAIT_STATES(2)) dut_w2 (
        .CLK(CLK), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2));

    mem_wait_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) dut_w0 (
        .CLK(CLK), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        step();
        init_we = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got, output int cycles);
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        got = 32'd0; cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ready2) begin
                cycles = i;
                got = rdata2;
                break;
            end
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; init_we = 1'b0;
        addr = 32'd0; wdata = 32'd0; init_addr = 32'd0; init_data = 32'd0;
        step(); step();
        chk("reset_rdata", rdata2, 32'd0);
        chk("reset_flags", {29'd0, ready2, busy2, err2}, 32'd0);
        reset = 1'b0;

        load(32'h00, 32'h8C010004);
        load(32'h04, 32'h44444444);
        load(32'h08, 32'h22222222);
        load(32'h14, 32'h11111111);
        load(32'h20, 32'h33333333);
        load(32'h30, 32'h77777777);

        // read of 0x0 with two wait states: ready on the third edge
        mem_rd = 1'b1; addr = 32'h0;
        step();
        chk("t1_busy_e1", {30'd0, busy2, ready2}, 32'd2);
        step();
        chk("t1_busy_e2", {30'd0, busy2, ready2}, 32'd2);
        step();
        chk("t1_ready_e3", {30'd0, busy2, ready2}, 32'd3);
        chk("t1_rdata", rdata2, 32'h8C010004);
        mem_rd = 1'b0;
        step();
        chk("t1_idle_after", {30'd0, busy2, ready2}, 32'd0);
        chk("t1_rdata_held", rdata2, 32'h8C010004);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, data, lat);
        chk("t2_wr_lat", lat, 32'd3);
        access(1'b1, 1'b0, 32'h10, 32'h0, data, lat);
        chk("t2_rd_0x10", data, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h14, 32'h0, data, lat);
        chk("t2_rd_0x14", data, 32'h11111111);

        mem_rd = 1'b1; addr = 32'h6;
        step();
        chk("t3_misalign", {29'd0, err2, busy2, ready2}, 32'd4);
        mem_rd = 1'b0;
        step();
        chk("t3_err_clear", {29'd0, err2, busy2, ready2}, 32'd0);
        mem_rd = 1'b1; mem_wr = 1'b1; addr = 32'h8; wdata = 32'hBAD0BAD0;
        step();
        chk("t3_rdwr", {29'd0, err2, busy2, ready2}, 32'd4);
        mem_rd = 1'b0; mem_wr = 1'b0;
        step();
        access(1'b1, 1'b0, 32'h8, 32'h0, data, lat);
        chk("t3_word8", data, 32'h22222222);

        // write abandoned after one WAIT cycle leaves the word untouched
        mem_wr = 1'b1; addr = 32'h20; wdata = 32'h55555555;
        step();
        chk("t4_busy", {30'd0, busy2, ready2}, 32'd2);
        mem_wr = 1'b0;
        step();
        chk("t4_abort", {30'd0, busy2, ready2}, 32'd0);
        access(1'b1, 1'b0, 32'h20, 32'h0, data, lat);
        chk("t4_word20", data, 32'h33333333);

        mem_rd = 1'b1; addr = 32'h0;
        step(); step();
        reset = 1'b1;
        step();
        chk("t4_rst_flags", {30'd0, busy2, ready2}, 32'd0);
        chk("t4_rst_rdata", rdata2, 32'd0);
        reset = 1'b0; mem_rd = 1'b0;
        step();

        // zero-wait instance: ready one edge after the request; index wraps at DEPTH
        mem_rd = 1'b1; addr = 32'h1004;
        step();
        chk("t5_w0_ready", {30'd0, ready0, err0}, 32'd2);
        chk("t5_w0_wrap", rdata0, 32'h44444444);
        chk("t5_w2_not_ready", {31'd0, ready2}, 32'd0);
        mem_rd = 1'b0;
        step();
        access(1'b1, 1'b0, 32'h1004, 32'h0, data, lat);
        chk("t5_w2_wrap", data, 32'h44444444);

        // loader ignored while a read is in flight
        mem_rd = 1'b1; addr = 32'h30;
        step();
        init_we = 1'b1; init_addr = 32'h30; init_data = 32'h66666666;
        step();
        init_we = 1'b0;
        step();
        chk("t6_busy_ready", {31'd0, ready2}, 32'd1);
        chk("t6_busy_rdata", rdata2, 32'h77777777);
        mem_rd = 1'b0;
        step();
        access(1'b1, 1'b0, 32'h30, 32'h0, data, lat);
        chk("t6_ignored", data, 32'h77777777);
        load(32'h30, 32'h66666666);
        access(1'b1, 1'b0, 32'h30, 32'h0, data, lat);
        chk("t6_written", data, 32'h66666666);
        chk("t6_lat", lat, 32'd3);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
